tog_sync_arb: RTL and testbench

//  Source-domain (clkA) arbiter and sequencer for the tog_sync toggle-pulse CDC.

---
 rtl/tog_sync_pkg.sv | 10 +
 rtl/tog_sync_arb_if.sv | 26 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/tog_sync_arb.sv | 90 +++++++++
 tb/tb_tog_sync_arb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/tog_sync_pkg.sv
// Shared types and helpers for the tog_sync source-side arbiter.
package tog_sync_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} arb_state_t;

  function automatic int cnt_width(input int gap);
    return (gap <= 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/tog_sync_arb_if.sv
// Requester/arbiter bundle: level requests and packed words in, grant and tog_sync drive out.
interface tog_sync_arb_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_id;
  logic [N-1:0]      data_in;
  logic              pulse_in;
  logic              busy;

  modport master (
    output req, req_data,
    input  grant, grant_id, data_in, pulse_in, busy
  );

  modport slave (
    input  req, req_data,
    output grant, grant_id, data_in, pulse_in, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    // Lower copy keeps only bits >= ptr; the untouched upper copy supplies the wrap-around.
    masked = dbl & ({(2*NREQ){1'b1}} << ptr);
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      if (masked[i] && !valid) begin
        valid = 1'b1;
        idx   = IW'(i % NREQ);
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/tog_sync_arb.sv
// Round-robin sequencer sharing one tog_sync: grant, launch pulse, then hold data_in for GAP cycles.
module tog_sync_arb
  import tog_sync_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int GAP  = 6
) (
  input logic           clkA,
  input logic           rst,
  tog_sync_arb_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_width(GAP);

  arb_state_t      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clkA) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.data_in  <= '0;
      bus.pulse_in <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            bus.grant    <= arb_gnt;
            bus.grant_id <= arb_idx;
            bus.data_in  <= bus.req_data[arb_idx*N +: N];
            bus.busy     <= 1'b1;
            ptr          <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + IW'(1);
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.grant    <= '0;
          bus.pulse_in <= 1'b1;
          cnt          <= CW'(GAP-1);
          state        <= HOLD;
        end
        HOLD: begin
          bus.pulse_in <= 1'b0;
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  int gap_cnt;

  always_ff @(posedge clkA) begin
    if (rst)                    gap_cnt <= GAP + 2;
    else if (bus.pulse_in)      gap_cnt <= 1;
    else if (gap_cnt < GAP + 2) gap_cnt <= gap_cnt + 1;
  end

  a_pulse_single: assert property (@(posedge clkA) disable iff (rst)
    bus.pulse_in |=> !bus.pulse_in);

  a_pulse_spacing: assert property (@(posedge clkA) disable iff (rst)
    $rose(bus.pulse_in) |-> (gap_cnt >= GAP + 2));
`endif

endmodule

// File: tb/tb_tog_sync_arb.sv
// Bench for tog_sync_arb with a behavioural tog_sync destination on clkB.
module tb_tog_sync_arb;
  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int GAP  = 6;
  localparam int IW   = 2;

  logic clkA = 1'b0;
  logic clkB = 1'b0;
  logic rst  = 1'b1;
  bit   auto_drop = 1'b1;
  bit   rand_en   = 1'b0;

  tog_sync_arb_if #(.N(N), .NREQ(NREQ)) bus();

  tog_sync_arb #(.N(N), .NREQ(NREQ), .GAP(GAP)) dut (
    .clkA (clkA),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clkA = ~clkA;
  initial begin
    #2;
    forever #10 clkB = ~clkB;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int             id;
    logic [N-1:0]   data;
  } gev_t;

  gev_t         gq[$];
  logic [N-1:0] dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level arbitration with a "free from cycle" bound
  int           cyc      = 0;
  int           m_ptr    = 0;
  int           m_free   = 0;
  int           m_last_g = -1000;
  int           m_id     = 0;
  logic [N-1:0] m_data   = '0;

  initial forever begin
    @(posedge clkA);
    cyc++;
    if (rst) begin
      m_ptr    = 0;
      m_free   = cyc + 1;
      m_last_g = -1000;
      m_id     = 0;
      m_data   = '0;
    end else if (cyc >= m_free && bus.req != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_id     = w;
      m_data   = bus.req_data[w*N +: N];
      m_last_g = cyc;
      m_ptr    = (w + 1) % NREQ;
      m_free   = cyc + GAP + 2;
      gq.push_back('{w, m_data});
      dq.push_back(m_data);
    end
  end

  initial forever begin
    logic [NREQ-1:0] eg;
    gev_t            g;
    @(negedge clkA);
    if (cyc > 0) begin
      eg = (cyc == m_last_g) ? (NREQ'(1) << m_id) : '0;
      chk("grant",    32'(bus.grant),    32'(eg));
      chk("pulse_in", 32'(bus.pulse_in), 32'(cyc == m_last_g + 1));
      chk("busy",     32'(bus.busy),     32'(cyc >= m_last_g && cyc <= m_last_g + GAP));
      chk("data_in",  32'(bus.data_in),  32'(m_data));
      chk("grant_id", 32'(bus.grant_id), 32'(m_id[IW-1:0]));
      if (bus.grant != '0) begin
        chk("grant_expected", 32'(gq.size() != 0), 32'(1));
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("grant_q_id",   32'(bus.grant_id), 32'(g.id));
          chk("grant_q_data", 32'(bus.data_in),  32'(g.data));
        end
      end
    end
  end

  // Destination side: toggle in clkA, 2-FF sync plus edge detect in clkB
  logic         tog = 1'b0;
  logic         s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic         pulse_out = 1'b0;
  logic [N-1:0] data_out  = '0;

  always @(posedge clkA) begin
    if (rst)               tog <= 1'b0;
    else if (bus.pulse_in) tog <= ~tog;
  end

  always @(posedge clkB) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      pulse_out <= 1'b0;
      data_out  <= '0;
    end else begin
      s1 <= tog;
      s2 <= s1;
      s3 <= s2;
      pulse_out <= s2 ^ s3;
      if (s2 ^ s3) data_out <= bus.data_in;
    end
  end

  initial forever begin
    @(negedge clkB);
    if (pulse_out) begin
      chk("dest_expected", 32'(dq.size() != 0), 32'(1));
      if (dq.size() != 0) chk("data_out", 32'(data_out), 32'(dq.pop_front()));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clkA);
      for (int i = 0; i < NREQ; i++) begin
        if (auto_drop && bus.grant[i]) begin
          bus.req[i] = 1'b0;
        end else if (rand_en && !bus.req[i] && $urandom_range(0, 5) == 0) begin
          bus.req_data[i*N +: N] = N'($urandom);
          bus.req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    dq.delete();
    step(4);
    rst = 1'b0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    step(4);
    rst = 1'b0;
    step(20);

    bus.req_data[7:0] = 8'hAA;
    bus.req = 4'b0001;
    step(30);

    do_reset();
    auto_drop = 1'b0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111;
    step(38);
    bus.req = '0;
    auto_drop = 1'b1;
    step(30);

    do_reset();
    bus.req_data[23:16] = 8'h77;
    bus.req = 4'b0100;
    step(15);
    bus.req_data[7:0]   = 8'hFF;
    bus.req_data[31:24] = 8'h3C;
    bus.req = 4'b1001;
    step(30);

    bus.req_data[7:0] = 8'h5C;
    bus.req = 4'b0001;
    step(4);
    bus.req_data[23:16] = 8'hC5;
    bus.req[2] = 1'b1;
    step(30);

    bus.req_data[7:0] = 8'h99;
    bus.req = 4'b0001;
    step(3);
    do_reset();
    bus.req_data[15:8] = 8'h5A;
    bus.req = 4'b0010;
    step(30);

    rand_en = 1'b1;
    step(1500);
    rand_en = 1'b0;
    bus.req = '0;
    step(40);

    chk("grant_queue_drained", 32'(gq.size()), 32'(0));
    chk("dest_queue_drained",  32'(dq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
